// File: rtl/link_pkg.sv
// Shared types and constants for the serial link partner model.
package link_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_LOW,
    GEN_HIGH
  } link_gen_t;

  typedef logic [2:0] link_bitcnt_t;

  localparam logic [7:0]   LINK_IDLE_BYTE = 8'hFF;
  localparam link_bitcnt_t LINK_LAST_BIT  = 3'd7;

endpackage

// File: rtl/link_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with single-cycle rise/fall strobes.
module link_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/link_partner.sv
// Far end of the serial link cable: clocks a byte back to the console (passive)
// or generates SCK itself (active). MSB first, shift on SCK fall, sample on SCK rise.
module link_partner
  import link_pkg::*;
#(
  parameter int unsigned SCK_HALF_PERIOD = 256,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [7:0]  IDLE_BYTE       = LINK_IDLE_BYTE,
  parameter int unsigned TIMEOUT         = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active_mode,
  input  logic       start,
  input  logic       sck_in,
  input  logic       so_in,
  output logic       sck_out,
  output logic       sck_oe,
  output logic       si_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int unsigned        HALF_W    = $clog2(SCK_HALF_PERIOD);
  localparam logic [HALF_W-1:0]  HALF_LAST = HALF_W'(SCK_HALF_PERIOD - 1);
  localparam int unsigned        TO_W      = 16;
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic               TO_EN     = (TIMEOUT != 0);

  logic sck_rise_c, sck_fall_c, so_sync;
  logic sck_level_unused, so_rise_unused, so_fall_unused;

  link_gen_t         gen_q, gen_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              sck_out_d, sck_oe_d;
  logic              gen_rise_c, gen_fall_c;

  link_bitcnt_t      cnt_q;
  logic [7:0]        tx_sr_q, rx_sr_q, hold_data_q;
  logic              hold_full_q, tx_loaded_q, mode_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic       rise_ev_c, fall_ev_c, abort_c, timeout_hit_c, reload_c;
  logic       accept_c, promote_c;
  logic [7:0] reload_byte_c, rx_next_c;

  link_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (sck_in),
    .q      (sck_level_unused),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  link_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_so_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (so_in),
    .q      (so_sync),
    .rise_c (so_rise_unused),
    .fall_c (so_fall_unused)
  );

  assign busy     = (cnt_q != '0) || (gen_q != GEN_IDLE);
  assign tx_ready = ~hold_full_q;
  assign si_out   = tx_sr_q[7];

  assign rise_ev_c     = active_mode ? gen_rise_c : sck_rise_c;
  assign fall_ev_c     = active_mode ? gen_fall_c : sck_fall_c;
  assign timeout_hit_c = TO_EN && !active_mode && (cnt_q != '0) && !sck_rise_c &&
                         !sck_fall_c && (to_cnt_q == TO_LAST);
  assign abort_c       = ((active_mode != mode_q) && busy) || timeout_hit_c;
  assign reload_c      = abort_c || (rise_ev_c && (cnt_q == LINK_LAST_BIT));
  assign reload_byte_c = hold_full_q ? hold_data_q : IDLE_BYTE;
  assign rx_next_c     = {rx_sr_q[6:0], so_sync};
  assign accept_c      = tx_valid && !hold_full_q;
  // An idle shifter still holding the open-cable byte picks up a freshly buffered byte.
  assign promote_c     = !busy && hold_full_q && !tx_loaded_q && !rise_ev_c;

  // SCK generator state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_q   <= GEN_IDLE;
      half_q  <= '0;
      sck_out <= 1'b1;
      sck_oe  <= 1'b0;
    end else begin
      gen_q   <= gen_d;
      half_q  <= half_d;
      sck_out <= sck_out_d;
      sck_oe  <= sck_oe_d;
    end
  end

  // SCK generator next state; the cycle sck_out changes is the edge event
  always_comb begin
    gen_d      = gen_q;
    half_d     = HALF_W'(half_q + 1'b1);
    sck_out_d  = sck_out;
    sck_oe_d   = sck_oe;
    gen_rise_c = 1'b0;
    gen_fall_c = 1'b0;
    if (abort_c) begin
      gen_d     = GEN_IDLE;
      half_d    = '0;
      sck_out_d = 1'b1;
      sck_oe_d  = 1'b0;
    end else begin
      case (gen_q)
        GEN_IDLE: begin
          half_d = '0;
          if (start && active_mode && !busy) begin
            gen_d     = GEN_LOW;
            sck_out_d = 1'b0;
            sck_oe_d  = 1'b1;
          end
        end
        GEN_LOW: begin
          if (half_q == HALF_LAST) begin
            gen_d      = GEN_HIGH;
            half_d     = '0;
            sck_out_d  = 1'b1;
            gen_rise_c = 1'b1;
          end
        end
        GEN_HIGH: begin
          if (half_q == HALF_LAST) begin
            half_d = '0;
            if (cnt_q != '0) begin
              gen_d      = GEN_LOW;
              sck_out_d  = 1'b0;
              gen_fall_c = 1'b1;
            end else begin
              gen_d    = GEN_IDLE;
              sck_oe_d = 1'b0;
            end
          end
        end
        default: begin
          gen_d     = GEN_IDLE;
          sck_out_d = 1'b1;
          sck_oe_d  = 1'b0;
        end
      endcase
    end
  end

  // Shift registers, bit counter, holding register and passive timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      tx_sr_q     <= IDLE_BYTE;
      rx_sr_q     <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      tx_loaded_q <= 1'b0;
      mode_q      <= 1'b0;
      to_cnt_q    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      mode_q   <= active_mode;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      if (accept_c) begin
        hold_data_q <= tx_data;
        hold_full_q <= 1'b1;
      end else if ((reload_c || promote_c) && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (abort_c) begin
        cnt_q       <= '0;
        rx_sr_q     <= '0;
        rx_err      <= 1'b1;
        tx_sr_q     <= reload_byte_c;
        tx_loaded_q <= hold_full_q;
      end else if (rise_ev_c) begin
        rx_sr_q <= rx_next_c;
        cnt_q   <= link_bitcnt_t'(cnt_q + 3'd1);
        if (cnt_q == LINK_LAST_BIT) begin
          rx_data     <= rx_next_c;
          rx_valid    <= 1'b1;
          tx_sr_q     <= reload_byte_c;
          tx_loaded_q <= hold_full_q;
        end
      end else if (fall_ev_c && (cnt_q != '0)) begin
        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
      end else if (promote_c) begin
        tx_sr_q     <= hold_data_q;
        tx_loaded_q <= 1'b1;
      end

      if (abort_c || active_mode || (cnt_q == '0) || sck_rise_c || sck_fall_c) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_link_partner.sv
// Scoreboarded bench for link_partner: DMG-side stimulus in both roles, event monitor on rx_valid/rx_err.
module tb_link_partner;

  localparam int unsigned PH = 10;

  logic       clk, reset, active_mode, start, sck_in, so_in;
  logic       sck_out, sck_oe, si_out, tx_valid, tx_ready, rx_valid, rx_err, busy;
  logic [7:0] tx_data, rx_data;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   errors   = 0;

  link_partner #(
    .SCK_HALF_PERIOD (4),
    .SYNC_STAGES     (2),
    .IDLE_BYTE       (8'hFF),
    .TIMEOUT         (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .active_mode (active_mode),
    .start       (start),
    .sck_in      (sck_in),
    .so_in       (so_in),
    .sck_out     (sck_out),
    .sck_oe      (sck_oe),
    .si_out      (si_out),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [7:0] data);
    exp_q.push_back({is_err, data});
  endtask

  // Monitor: every rx_valid / rx_err pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (rx_valid || rx_err) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: valid=%0b err=%0b data=%h, expected no event",
                 rx_valid, rx_err, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_err !== mon_e.is_err || rx_valid !== !mon_e.is_err || rx_data !== mon_e.data) begin
          errors++;
          $display("FAIL rx_event: got valid=%0b err=%0b data=%h expected valid=%0b err=%0b data=%h",
                   rx_valid, rx_err, rx_data, !mon_e.is_err, mon_e.is_err, mon_e.data);
        end
      end
    end
  end

  // Offer a byte and hold tx_valid until the cycle it is accepted
  task automatic offer(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (tx_ready) done = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (!done) begin
      n_checks++;
      errors++;
      $display("FAIL offer_timeout: tx_ready got %0b expected 1", tx_ready);
    end
  endtask

  // DMG drives SCK: data out on fall, samples si_out just before its rise
  task automatic dmg_xfer(input logic [7:0] b, input int nbits, output logic [7:0] got);
    logic [2:0] bi;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bi     = 3'(7 - i);
      sck_in = 1'b0;
      so_in  = b[bi];
      repeat (PH) @(negedge clk);
      got[bi] = si_out;
      sck_in  = 1'b1;
      repeat (PH) @(negedge clk);
    end
  endtask

  logic [7:0] got, got1, got_a;
  int         oe_cycles, rises, last_rise, wait_n;
  logic       prev_sck, prev_si, period_ok;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "Simulation finished: %0d checks, %0d errors", n_checks, errors + 1);
  end

  initial begin
    reset = 1'b1; sck_in = 1'b1; so_in = 1'b1; active_mode = 1'b0;
    start = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_bit("rst_sck_out", sck_out, 1'b1);
    check_bit("rst_sck_oe", sck_oe, 1'b0);
    check_bit("rst_si_out", si_out, 1'b1);
    check_bit("rst_tx_ready", tx_ready, 1'b1);
    check_byte("rst_rx_data", rx_data, 8'h00);
    check_bit("rst_rx_valid", rx_valid, 1'b0);
    check_bit("rst_rx_err", rx_err, 1'b0);
    check_bit("rst_busy", busy, 1'b0);

    // Passive byte with a buffered tx byte
    offer(8'hA5);
    expect_ev(1'b0, 8'h3C);
    dmg_xfer(8'h3C, 8, got);
    check_byte("t1_si_bits", got, 8'hA5);
    repeat (5) @(negedge clk);
    check_byte("t1_rx_data", rx_data, 8'h3C);
    check_bit("t1_tx_ready", tx_ready, 1'b1);

    // Passive byte with nothing buffered: open-cable value goes out
    expect_ev(1'b0, 8'h00);
    dmg_xfer(8'h00, 8, got);
    check_byte("t2_si_idle", got, 8'hFF);
    repeat (5) @(negedge clk);
    check_byte("t2_rx_data", rx_data, 8'h00);

    // Back-to-back: second byte accepted while the first is on the wire
    offer(8'h11);
    expect_ev(1'b0, 8'h5A);
    expect_ev(1'b0, 8'hC3);
    fork
      dmg_xfer(8'h5A, 8, got1);
      begin
        repeat (30) @(negedge clk);
        check_bit("t4_busy_at_offer", busy, 1'b1);
        offer(8'h22);
        check_bit("t4_ready_full", tx_ready, 1'b0);
      end
    join
    check_byte("t4_byte1_bits", got1, 8'h11);
    repeat (5) @(negedge clk);
    check_bit("t4_ready_after_reload1", tx_ready, 1'b1);
    dmg_xfer(8'hC3, 8, got);
    check_byte("t4_byte2_bits", got, 8'h22);
    repeat (5) @(negedge clk);
    check_bit("t4_ready_after_reload2", tx_ready, 1'b1);
    check_bit("t4_si_idle", si_out, 1'b1);

    // Active role: partner generates 8 SCK periods of 8 clk
    active_mode = 1'b1;
    repeat (2) @(negedge clk);
    offer(8'h81);
    repeat (2) @(negedge clk);
    so_in = 1'b1;
    expect_ev(1'b0, 8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_sck = 1'b1; prev_si = si_out; oe_cycles = 0; rises = 0;
    last_rise = 0; period_ok = 1'b1; got_a = 8'h00;
    for (int n = 0; n < 200 && sck_oe; n++) begin
      if (sck_out && !prev_sck) begin
        if (rises > 0 && (n - last_rise) != 8) period_ok = 1'b0;
        if (rises < 8) got_a[3'(7 - rises)] = prev_si;
        rises++;
        last_rise = n;
      end
      prev_sck = sck_out;
      prev_si  = si_out;
      oe_cycles++;
      @(negedge clk);
    end
    check_int("t3_sck_rises", rises, 8);
    check_bit("t3_period_8clk", period_ok, 1'b1);
    check_int("t3_oe_cycles", oe_cycles, 64);
    check_byte("t3_si_bits", got_a, 8'h81);
    check_bit("t3_sck_idle_high", sck_out, 1'b1);
    repeat (3) @(negedge clk);
    check_byte("t3_rx_data", rx_data, 8'hFF);

    // Passive timeout after 3 bits: abort 100 clk after the last detected edge
    active_mode = 1'b0;
    repeat (2) @(negedge clk);
    expect_ev(1'b1, 8'hFF);
    dmg_xfer(8'h96, 3, got);
    check_bit("t5_busy_mid", busy, 1'b1);
    wait_n = -1;
    for (int n = 0; n < 300 && wait_n < 0; n++) begin
      if (rx_err) wait_n = n;
      else @(negedge clk);
    end
    n_checks++;
    if (wait_n < 90 || wait_n > 96) begin
      errors++;
      $display("FAIL t5_timeout_latency: got %0d clk expected 93 +/- 3", wait_n);
    end
    @(negedge clk);
    check_bit("t5_busy_after", busy, 1'b0);
    check_byte("t5_rx_data_kept", rx_data, 8'hFF);
    check_bit("t5_si_reload", si_out, 1'b1);

    // Reset during bit 5 of an active byte
    active_mode = 1'b1;
    repeat (2) @(negedge clk);
    offer(8'h00);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_sck = 1'b1; rises = 0; wait_n = -1;
    for (int n = 0; n < 200 && wait_n < 0; n++) begin
      if (sck_out && !prev_sck) rises++;
      prev_sck = sck_out;
      if (rises >= 5 && !sck_out) wait_n = n;
      else @(negedge clk);
    end
    check_bit("t6_pre_sck_low", sck_out, 1'b0);
    check_bit("t6_pre_si", si_out, 1'b0);
    check_bit("t6_pre_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("t6_sck_out", sck_out, 1'b1);
    check_bit("t6_sck_oe", sck_oe, 1'b0);
    check_bit("t6_si_out", si_out, 1'b1);
    check_bit("t6_busy", busy, 1'b0);
    check_bit("t6_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check_byte("t6_rx_data", rx_data, 8'h00);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
    $finish;
  end

endmodule
